// File: rtl/peak_locator.sv
// Streaming peak finder: per-frame maximum, its location and the above-threshold hit count.
// Latency: the result appears 2 clk_en cycles after the last beat. No input backpressure; the result is held until acknowledged.
module peak_locator #(
  parameter int ROI_SIZE      = 470,
  parameter int NUM_PER_CYCLE = 2,
  parameter int IN_WIDTH      = 28,
  parameter int CNT_WIDTH     = $clog2(ROI_SIZE*ROI_SIZE+1)
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             clk_en,
  input  logic signed [NUM_PER_CYCLE-1:0][IN_WIDTH-1:0]    din,
  input  logic                                             din_valid,
  input  logic signed [IN_WIDTH-1:0]                       threshold,
  output logic        [$clog2(ROI_SIZE)-1:0]               peak_x,
  output logic        [$clog2(ROI_SIZE)-1:0]               peak_y,
  output logic signed [IN_WIDTH-1:0]                       peak_val,
  output logic        [CNT_WIDTH-1:0]                      hit_count,
  output logic                                             peak_found,
  output logic                                             result_valid,
  input  logic                                             result_ready,
  output logic                                             busy,
  output logic                                             overrun
);

  localparam int XW = $clog2(ROI_SIZE);
  localparam int LW = $clog2(NUM_PER_CYCLE+1);
  localparam logic [XW-1:0] LAST_COL = XW'(ROI_SIZE - NUM_PER_CYCLE);
  localparam logic [XW-1:0] LAST_ROW = XW'(ROI_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;
  state_t state;

  logic          accept, beat_first, beat_last;
  logic [XW-1:0] col, row;

  assign accept     = clk_en && din_valid;
  assign beat_first = (col == '0) && (row == '0);
  assign beat_last  = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + XW'(NUM_PER_CYCLE);
      end
    end
  end

  // Lane reduction; strict compare keeps the lowest lane on ties.
  logic signed [IN_WIDTH-1:0] lane_max;
  logic [XW-1:0]              lane_x;
  logic [LW-1:0]              lane_cnt;

  always_comb begin
    lane_max = $signed(din[0]);
    lane_x   = col;
    lane_cnt = '0;
    for (int n = 0; n < NUM_PER_CYCLE; n++) begin
      if ($signed(din[n]) > lane_max) begin
        lane_max = $signed(din[n]);
        lane_x   = col + XW'(n);
      end
      if ($signed(din[n]) > threshold) lane_cnt = lane_cnt + 1'b1;
    end
  end

  logic                       s1_vld, s1_first, s1_last;
  logic signed [IN_WIDTH-1:0] s1_max, s1_thr;
  logic [XW-1:0]              s1_x, s1_y;
  logic [LW-1:0]              s1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_max   <= '0;
      s1_thr   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_cnt   <= '0;
    end else if (clk_en) begin
      s1_vld <= din_valid;
      if (din_valid) begin
        s1_first <= beat_first;
        s1_last  <= beat_last;
        s1_max   <= lane_max;
        s1_thr   <= threshold;
        s1_x     <= lane_x;
        s1_y     <= row;
        s1_cnt   <= lane_cnt;
      end
    end
  end

  logic signed [IN_WIDTH-1:0] run_max, nxt_max;
  logic [XW-1:0]              run_x, run_y, nxt_x, nxt_y;
  logic [CNT_WIDTH-1:0]       run_hits, nxt_hits;
  logic                       take, load;

  assign take     = s1_first || (s1_max > run_max);
  assign nxt_max  = take ? s1_max : run_max;
  assign nxt_x    = take ? s1_x : run_x;
  assign nxt_y    = take ? s1_y : run_y;
  assign nxt_hits = s1_first ? CNT_WIDTH'(s1_cnt) : run_hits + CNT_WIDTH'(s1_cnt);
  assign load     = clk_en && s1_vld && s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max  <= '0;
      run_x    <= '0;
      run_y    <= '0;
      run_hits <= '0;
    end else if (clk_en && s1_vld) begin
      run_max  <= nxt_max;
      run_x    <= nxt_x;
      run_y    <= nxt_y;
      run_hits <= nxt_hits;
    end
  end

  // A new frame result takes priority over an acknowledge in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_x       <= '0;
      peak_y       <= '0;
      peak_val     <= {1'b1, {(IN_WIDTH-1){1'b0}}};
      hit_count    <= '0;
      peak_found   <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      peak_x       <= nxt_x;
      peak_y       <= nxt_y;
      peak_val     <= nxt_max;
      hit_count    <= nxt_hits;
      peak_found   <= nxt_max > s1_thr;
      result_valid <= 1'b1;
      if (result_valid && !result_ready) overrun <= 1'b1;
    end else if (clk_en && result_ready) begin
      result_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (din_valid) begin
          state <= beat_last ? FLUSH : ACC;
          busy  <= 1'b1;
        end
        ACC: if (din_valid && beat_last) state <= FLUSH;
        FLUSH: begin
          if (din_valid) begin
            state <= beat_last ? FLUSH : ACC;
          end else if (s1_vld && s1_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peak_locator.sv
// Directed bench for peak_locator on an 8x8 frame with two pixels per beat.
module tb_peak_locator;
  localparam int ROI = 8;
  localparam int NPC = 2;
  localparam int IW  = 28;
  localparam int BPF = ROI * ROI / NPC;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, din_valid = 1'b0, result_ready = 1'b0;
  logic signed [NPC-1:0][IW-1:0] din = '0;
  logic signed [IW-1:0] threshold = '0;
  logic [2:0] peak_x, peak_y;
  logic signed [IW-1:0] peak_val;
  logic [6:0] hit_count;
  logic peak_found, result_valid, busy, overrun;

  int pix [ROI][ROI];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  peak_locator #(.ROI_SIZE(ROI), .NUM_PER_CYCLE(NPC), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .din(din), .din_valid(din_valid),
    .threshold(threshold), .peak_x(peak_x), .peak_y(peak_y), .peak_val(peak_val),
    .hit_count(hit_count), .peak_found(peak_found), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int y = 0; y < ROI; y++)
      for (int x = 0; x < ROI; x++) pix[y][x] = v;
  endtask

  task automatic send_beats(input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      int y, x;
      y = b / (ROI / NPC);
      x = (b % (ROI / NPC)) * NPC;
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          if ($urandom_range(0, 1) == 1) begin
            clk_en = 1'b0; din_valid = 1'b1; din = '1;
          end else begin
            clk_en = 1'b1; din_valid = 1'b0;
          end
          @(negedge clk);
        end
        clk_en = 1'b1;
      end
      for (int n = 0; n < NPC; n++) din[n] = IW'(pix[y][x+n]);
      din_valid = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic check_outputs(input string tag, input int px, input int py, input int pv,
                               input int hc, input int pf);
    check({tag, "_px"}, peak_x, px);
    check({tag, "_py"}, peak_y, py);
    check({tag, "_pv"}, peak_val, pv);
    check({tag, "_hc"}, hit_count, hc);
    check({tag, "_pf"}, peak_found, pf);
  endtask

  task automatic wait_result(input string tag);
    int k;
    k = 0;
    while (!result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) check({tag, "_timeout"}, result_valid, 1);
  endtask

  task automatic ack(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_ack_clear"}, result_valid, 0);
  endtask

  task automatic frame_a();
    fill(-5);
    pix[3][5] = 100;
    threshold = 0;
  endtask

  task automatic frame_c();
    fill(-1);
    pix[4][2] = 50;
    pix[4][3] = 50;
    threshold = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check_outputs("rst", 0, 0, -134217728, 0, 0);
    rst_n = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);

    // Single peak, with exact result latency.
    frame_a();
    send_beats(BPF, 1'b0);
    din_valid = 1'b0;
    check("a_busy_flush", busy, 1);
    check("a_rv_lag1", result_valid, 0);
    @(negedge clk);
    check("a_rv_lag2", result_valid, 1);
    check("a_busy_done", busy, 0);
    check_outputs("a", 5, 3, 100, 1, 1);
    ack("a");

    // Equal maxima across beats: first occurrence wins.
    fill(-1);
    pix[0][1] = 50;
    pix[2][0] = 50;
    threshold = 0;
    send_beats(BPF, 1'b0);
    din_valid = 1'b0;
    wait_result("b");
    check_outputs("b", 1, 0, 50, 2, 1);
    ack("b");

    // Lane tie within one beat: lowest lane wins.
    frame_c();
    send_beats(BPF, 1'b0);
    din_valid = 1'b0;
    wait_result("c");
    check_outputs("c", 2, 4, 50, 2, 1);
    ack("c");

    // Flat negative frame equal to the threshold.
    fill(-7);
    threshold = -7;
    send_beats(BPF, 1'b0);
    din_valid = 1'b0;
    wait_result("d");
    check_outputs("d", 0, 0, -7, 0, 0);
    ack("d");
    check("d_ovr", overrun, 0);

    // Back-to-back frames, never acknowledged: second overwrites the first.
    frame_a();
    send_beats(BPF, 1'b0);
    frame_c();
    send_beats(BPF, 1'b0);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bb_rv", result_valid, 1);
    check("bb_ovr", overrun, 1);
    check_outputs("bb", 2, 4, 50, 2, 1);
    ack("bb");
    check("bb_ovr_sticky", overrun, 1);

    // Same single-peak frame with valid gaps and clock-enable stalls.
    frame_a();
    send_beats(BPF, 1'b1);
    din_valid = 1'b0;
    clk_en = 1'b1;
    wait_result("g");
    check_outputs("g", 5, 3, 100, 1, 1);
    ack("g");

    // Reset mid-frame discards the partial frame and clears overrun.
    fill(1000);
    threshold = 0;
    send_beats(11, 1'b0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("r_ovr", overrun, 0);
    check("r_rv", result_valid, 0);
    check("r_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    fill(0);
    pix[7][7] = 9;
    send_beats(BPF, 1'b0);
    din_valid = 1'b0;
    wait_result("r");
    check_outputs("r", 7, 7, 9, 1, 1);
    check("r_ovr_after", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
